event_or_sched: RTL
===================

// Module: event_or_sched
// PURPOSE
// - Parametrised event-OR scheduler: N_CH strobe inputs, plus an optional internal periodic tick, are OR-combined into one trigger.
// - Each trigger starts a job with two timed actions on a fixed timeline:
//   - a delayed sum b = a + c at DLY_B cycles;
//   - REPEAT emissions of c1 = a + b at multiples of DLY_C.
// - Triggers that arrive while a job runs are merged into a 1-deep pending slot instead of being lost.
// - Sits between event sources (timers, status strobes) and the datapath consuming c1.
// PARAMETERS
// - WIDTH        4    operand/result width; all sums wrap modulo 2**WIDTH
// - N_CH         2    number of external event strobe channels
// - DLY_B        10   edges from the trigger edge to the b_o update
// - DLY_C        20   c1 emission period in edges, measured from the trigger edge
// - REPEAT       2    c1 emissions per job (>=1)
// - TICK_PERIOD  0    0 = tick disabled; else internal tick every TICK_PERIOD cycles
// - MCNT_W       8    width of the saturating merge counter
// - Elaboration error if DLY_B < 1, DLY_B >= DLY_C, or REPEAT < 1.
// PORTS
// - clk         in   1        single clock, rising edge
// - rst         in   1        asynchronous, active-high reset
// - ev          in   N_CH     event strobes, sampled at rising edge; any bit high = trigger
// - a_i         in   WIDTH    operand a, snapshot at trigger
// - c_i         in   WIDTH    operand c, snapshot at trigger
// - b_o         out  WIDTH    delayed sum a+c
// - c1_o        out  WIDTH    emitted sum a+b
// - c1_valid    out  1        one-cycle pulse per c1 emission
// - src_mask_o  out  N_CH+1   sources of the running job; bit N_CH = tick
// - busy        out  1        job in progress
// - pending     out  1        pending slot occupied
// - merge_cnt   out  MCNT_W   saturating count of triggers merged into an occupied pending slot
// BEHAVIOUR
// - Reset (async, any time, including mid-job): all outputs 0, FSM to IDLE, pending cleared, tick counter 0.
// - trig = |ev | tick, where tick is high for one cycle when the tick counter == TICK_PERIOD-1.
// - Tick counter: free-running from reset, wraps to 0 after TICK_PERIOD-1.
// - FSM IDLE -> RUN:
//   - trig seen at edge E0 in IDLE starts the job;
//   - at E0, snapshot a_i/c_i, load src_mask_o, set busy=1, set the cycle counter to 1.
// - RUN timeline, counting edges k after E0:
//   - k == DLY_B: b_o <= a_s + c_s.
//   - k == j*DLY_C for j = 1..REPEAT: c1_o <= a_s + b_o; c1_valid high for the following cycle.
// - RUN -> IDLE/RUN at completion edge k == REPEAT*DLY_C:
//   - pending empty -> IDLE, busy=0;
//   - pending full -> that edge is E0 of the pending job: pending operands/mask load, pending=0.
// - Trigger while RUN, pending empty: store a_i/c_i/mask into the pending slot, pending=1.
// - Trigger while RUN, pending full:
//   - overwrite pending operands with the newest values;
//   - OR the new sources into the pending mask;
//   - merge_cnt++, saturating at all-ones.
// - Trigger on the completion edge:
//   - pending empty -> it is E0 of the new job directly;
//   - pending full -> pending starts and the new trigger refills the slot.
// - b_o and c1_o hold their value between updates and are not cleared at job end.
// - Carries are discarded; no overflow flag.
// - Cycle-counter width = $clog2(REPEAT*DLY_C+1).
// STRUCTURE
// - event_or_pkg:
//   - state_t enum {IDLE, RUN};
//   - cycle-counter width function;
//   - parameter legality checks.
// - Sub-module event_or_tick: TICK_PERIOD counter giving a one-cycle tick; tied off when TICK_PERIOD == 0.
// - Top: trigger OR, pending slot, FSM/timeline counter, adders.
// TESTING
// - Reset: assert rst mid-idle -> every output 0; tick counter restarts from 0.
// - Basic job: ev=01, a=5, c=4 at E0 -> b_o=9 at edge 10; c1_o=14 with c1_valid at edges 20 and 40; busy=0 after edge 40.
// - Wrap: a=15, c=3 -> b_o=2; c1_o=1 (17 mod 16) at both emissions.
// - Merge, job started at edge 0:
//   - ev=01 with a=1, c=1 at edge 5, then ev=10 with a=2, c=2 at edge 7 -> pending=1, merge_cnt=1;
//   - next job starts at edge 40 with src_mask_o=011 -> b_o=4 at edge 50; c1_o=6 at edges 60 and 80.
// - Tick: TICK_PERIOD=50, ev=0 -> job with src_mask_o=100 at edge 49; tick coinciding with ev[0] -> src_mask_o=101.
// - Reset mid-job at edge 15 -> b_o, c1_o, busy, pending, merge_cnt 0; no c1_valid at edge 20.

Source files
------------

// File: rtl/event_or_pkg.sv
// rtl/event_or_pkg.sv - shared types and elaboration helpers for the event-OR scheduler
package event_or_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // Timeline counter must reach REPEAT*DLY_C, the completion edge.
  function automatic int cnt_width(input int rep, input int dly_c);
    return $clog2(rep * dly_c + 1);
  endfunction

  function automatic bit params_ok(input int dly_b, input int dly_c, input int rep);
    return (dly_b >= 1) && (dly_b < dly_c) && (rep >= 1);
  endfunction

endpackage

// File: rtl/event_or_tick.sv
// rtl/event_or_tick.sv - free-running periodic tick, one-cycle pulse every TICK_PERIOD cycles
module event_or_tick #(
  parameter int TICK_PERIOD = 50
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);
  localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_PERIOD - 1);

  logic [TW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/event_or_sched.sv
// rtl/event_or_sched.sv - event-OR trigger scheduler with pending slot and timed b/c1 updates
module event_or_sched
  import event_or_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int N_CH        = 2,
  parameter int DLY_B       = 10,
  parameter int DLY_C       = 20,
  parameter int REPEAT      = 2,
  parameter int TICK_PERIOD = 0,
  parameter int MCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ev,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  c_i,
  output logic [WIDTH-1:0]  b_o,
  output logic [WIDTH-1:0]  c1_o,
  output logic              c1_valid,
  output logic [N_CH:0]     src_mask_o,
  output logic              busy,
  output logic              pending,
  output logic [MCNT_W-1:0] merge_cnt
);
  localparam int CW = cnt_width(REPEAT, DLY_C);
  localparam logic [CW-1:0] K_B    = CW'(DLY_B);
  localparam logic [CW-1:0] K_DONE = CW'(REPEAT * DLY_C);

  if (!params_ok(DLY_B, DLY_C, REPEAT)) begin : g_bad_params
    $error("event_or_sched: need 1 <= DLY_B < DLY_C and REPEAT >= 1");
  end

  logic w_tick;
  if (TICK_PERIOD > 0) begin : g_tick
    event_or_tick #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
      .i_clk  (clk),
      .i_rst  (rst),
      .o_tick (w_tick)
    );
  end else begin : g_no_tick
    assign w_tick = 1'b0;
  end

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_c, r_pa, r_pc;
  logic [N_CH:0]    r_pmask;

  logic          w_trig, w_done, w_emit;
  logic          w_load_new, w_load_pend, w_fill, w_merge;
  logic [N_CH:0] w_mask;

  assign w_trig = (|ev) | w_tick;
  assign w_mask = {w_tick, ev};
  assign w_done = (r_state == RUN) && (r_cnt == K_DONE);
  assign busy   = (r_state == RUN);

  always_comb begin
    w_emit = 1'b0;
    for (int j = 1; j <= REPEAT; j++) begin
      if (r_cnt == CW'(j * DLY_C)) w_emit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The completion edge doubles as E0 of the next job when one is waiting.
  always_comb begin
    w_state_nxt = r_state;
    w_load_new  = 1'b0;
    w_load_pend = 1'b0;
    w_fill      = 1'b0;
    w_merge     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_nxt = RUN;
          w_load_new  = 1'b1;
        end
      end
      RUN: begin
        if (w_done) begin
          if (pending) begin
            w_load_pend = 1'b1;
            w_fill      = w_trig;
          end else if (w_trig) begin
            w_load_new  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_trig) begin
          w_merge = pending;
          w_fill  = !pending;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_c        <= '0;
      r_pa       <= '0;
      r_pc       <= '0;
      r_pmask    <= '0;
      b_o        <= '0;
      c1_o       <= '0;
      c1_valid   <= 1'b0;
      src_mask_o <= '0;
      pending    <= 1'b0;
      merge_cnt  <= '0;
    end else begin
      c1_valid <= 1'b0;
      if (r_state == RUN) begin
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        if (r_cnt == K_B) b_o <= r_a + r_c;
        if (w_emit) begin
          c1_o     <= r_a + b_o;
          c1_valid <= 1'b1;
        end
      end
      if (w_load_new) begin
        r_a        <= a_i;
        r_c        <= c_i;
        src_mask_o <= w_mask;
        r_cnt      <= CW'(1);
      end
      if (w_load_pend) begin
        r_a        <= r_pa;
        r_c        <= r_pc;
        src_mask_o <= r_pmask;
        r_cnt      <= CW'(1);
        pending    <= 1'b0;
      end
      if (w_fill) begin
        r_pa    <= a_i;
        r_pc    <= c_i;
        r_pmask <= w_mask;
        pending <= 1'b1;
      end
      if (w_merge) begin
        r_pa    <= a_i;
        r_pc    <= c_i;
        r_pmask <= r_pmask | w_mask;
        if (merge_cnt != {MCNT_W{1'b1}}) merge_cnt <= merge_cnt + 1'b1;
      end
    end
  end

endmodule
